alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU (32-bit operands, 3-bit op, result plus zero/carryout/overflow flags) between two requesters. Requester 0 is the pipeline EX stage; requester 1 is the debug/LCD command port.
- Round-robin arbitration, valid/ready request handshake, registered ALU operands, registered result with per-requester response handshake.
- Sits between the requesters and the ALU instance. The ALU itself stays outside this block.

---
 rtl/alu_share_arbiter_pkg.sv | 27 ++
 rtl/alu_share_arbiter_if.sv | 51 +++++
 rtl/alu_share_arbiter_rr_arb2.sv | 19 +
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 tb/tb_alu_share_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: op codes, FSM states, flag payload.
package alu_share_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_OP_W   = 3;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carryout;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals around the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              resp0_valid;
  logic              resp0_ready;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero;
  logic              resp_carryout;
  logic              resp_overflow;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carryout;
  logic              alu_overflow;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready,
    input  alu_result, alu_zero, alu_carryout, alu_overflow,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_result, resp_zero, resp_carryout, resp_overflow,
    output alu_a, alu_b, alu_op
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready,
    output alu_result, alu_zero, alu_carryout, alu_overflow,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_result, resp_zero, resp_carryout, resp_overflow,
    input  alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any_c,
  output logic       winner_c
);

  always_comb begin
    any_c    = |valid;
    winner_c = 1'b0;
    if (valid == 2'b11) begin
      winner_c = ~last_grant;
    end else if (valid[1]) begin
      winner_c = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between the EX stage (req 0) and the debug port (req 1).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  state_e            state;
  state_e            state_nxt;
  logic              owner;
  logic              last_grant;
  logic [1:0]        resp_valid;
  logic [DATA_W-1:0] resp_result;
  alu_flags_t        resp_flags;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;

  logic              arb_any;
  logic              arb_winner;
  logic [1:0]        req_ready_c;
  logic              accept_c;
  logic              resp_take_c;

  rr_arb2 u_rr_arb2 (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .any_c      (arb_any),
    .winner_c   (arb_winner)
  );

  // Next state plus the combinational request-side ready (only ever one bit set).
  always_comb begin
    state_nxt   = state;
    req_ready_c = 2'b00;
    accept_c    = 1'b0;
    resp_take_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_c[arb_winner] = 1'b1;
          accept_c                = 1'b1;
          state_nxt               = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        resp_take_c = owner ? bus.resp1_ready : bus.resp0_ready;
        if (resp_take_c) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_flags  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
    end else begin
      state <= state_nxt;
      // Operands only move on an accept so the ALU inputs stay quiet otherwise.
      if (accept_c) begin
        alu_a      <= arb_winner ? bus.req1_a  : bus.req0_a;
        alu_b      <= arb_winner ? bus.req1_b  : bus.req0_b;
        alu_op     <= arb_winner ? bus.req1_op : bus.req0_op;
        owner      <= arb_winner;
        last_grant <= arb_winner;
      end
      if (state == ST_EXEC) begin
        resp_result        <= bus.alu_result;
        resp_flags         <= '{zero: bus.alu_zero, carryout: bus.alu_carryout,
                                overflow: bus.alu_overflow};
        resp_valid[owner]  <= 1'b1;
      end
      if (resp_take_c) begin
        resp_valid <= 2'b00;
      end
    end
  end

  assign bus.req0_ready    = req_ready_c[0];
  assign bus.req1_ready    = req_ready_c[1];
  assign bus.resp0_valid   = resp_valid[0];
  assign bus.resp1_valid   = resp_valid[1];
  assign bus.resp_result   = resp_result;
  assign bus.resp_zero     = resp_flags.zero;
  assign bus.resp_carryout = resp_flags.carryout;
  assign bus.resp_overflow = resp_flags.overflow;
  assign bus.alu_a         = alu_a;
  assign bus.alu_b         = alu_b;
  assign bus.alu_op        = alu_op;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, scoreboard of responses, and hand-written corner sequences.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(32), .OP_W(3)) bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference ALU sitting behind the alu_* ports.
  logic [32:0] alu_sum;
  logic [31:0] alu_res;
  logic        alu_cy;
  logic        alu_ov;
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    case (bus.alu_op)
      3'b000: alu_res = bus.alu_a & bus.alu_b;
      3'b001: alu_res = bus.alu_a | bus.alu_b;
      3'b010: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_res = alu_sum[31:0];
        alu_cy  = alu_sum[32];
        alu_ov  = (bus.alu_a[31] == bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
      end
      3'b110: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        alu_res = alu_sum[31:0];
        alu_cy  = alu_sum[32];
        alu_ov  = (bus.alu_a[31] != bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
      end
      3'b111: alu_res = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_result   = alu_res;
  assign bus.alu_zero     = (alu_res == 32'd0);
  assign bus.alu_carryout = alu_cy;
  assign bus.alu_overflow = alu_ov;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[9];
  vec_t cur[2];
  vec_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake; one-hot ready check.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      if (bus.req0_valid && bus.req0_ready) sb.push_back(cur[0]);
      if (bus.req1_valid && bus.req1_ready) sb.push_back(cur[1]);
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? (bus.resp0_valid && bus.resp0_ready)
                     : (bus.resp1_valid && bus.resp1_ready)) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_resp");
          end else begin
            vec_t e;
            e = sb.pop_front();
            chk("resp_owner", 32'(i), 32'(e.id));
            chk("resp_result", bus.resp_result, e.res);
            chk("resp_flags", 32'({bus.resp_zero, bus.resp_carryout, bus.resp_overflow}),
                32'({e.z, e.c, e.o}));
          end
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    cur[v.id] = v;
    if (v.id == 1'b0) begin
      bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_op = v.op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_op = v.op; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_sb_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now(name);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk({tag, "_rvalid"}, 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
    chk({tag, "_result"}, bus.resp_result, 32'd0);
    chk({tag, "_flags"}, 32'({bus.resp_zero, bus.resp_carryout, bus.resp_overflow}), 32'd0);
    chk({tag, "_alu_a"}, bus.alu_a, 32'd0);
    chk({tag, "_alu_b"}, bus.alu_b, 32'd0);
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int          order[$];
    int          idx[2];
    logic        acc[2];
    logic [31:0] held;
    vec_t        lst0[2];
    vec_t        lst1[2];

    vecs[0] = '{1'b0, 32'hFFFFFFDB, 32'hFFFFFFDB, 3'b110, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h12340000, 32'h00005678, 3'b001, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h00000005, 32'h00000003, 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    cur[0] = vecs[0]; cur[1] = vecs[1];
    rst_n = 1'b0;
    #12;
    chk_all_zero("reset");
    do_reset();
    @(negedge clk);
    chk_all_zero("post_reset");
    @(posedge clk); #1;

    // Table: one requester at a time, exact latency and single-owner response.
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      vec_t v;
      v = vecs[i];
      drive(v);
      @(negedge clk);
      chk("tbl_ready_own", 32'(v.id ? bus.req1_ready : bus.req0_ready), 32'd1);
      chk("tbl_ready_other", 32'(v.id ? bus.req0_ready : bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("tbl_exec_rvalid", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
      @(negedge clk);
      chk("tbl_resp_valid", 32'({bus.resp1_valid, bus.resp0_valid}), v.id ? 32'd2 : 32'd1);
      @(negedge clk);
      chk("tbl_resp_done", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
      @(posedge clk); #1;
    end

    // Contention: both valid from reset, grants must alternate starting with 0.
    do_reset();
    lst0[0] = vecs[2]; lst0[1] = vecs[4];
    lst1[0] = vecs[3]; lst1[1] = vecs[5];
    idx[0] = 0; idx[1] = 0;
    drive(lst0[0]);
    drive(lst1[0]);
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      acc[0] = bus.req0_valid && bus.req0_ready;
      acc[1] = bus.req1_valid && bus.req1_ready;
      if (acc[0]) order.push_back(0);
      if (acc[1]) order.push_back(1);
      @(posedge clk); #1;
      if (acc[0]) begin
        idx[0]++;
        if (idx[0] < 2) drive(lst0[idx[0]]); else bus.req0_valid = 1'b0;
      end
      if (acc[1]) begin
        idx[1]++;
        if (idx[1] < 2) drive(lst1[idx[1]]); else bus.req1_valid = 1'b0;
      end
    end
    chk("cont_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) chk("cont_order", 32'(order[k]), 32'(k % 2));
    end
    wait_sb_empty("cont_drain");

    // Idle: operands hold the last accepted op (req1 SUB 80000000 - 1).
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_alu_a", bus.alu_a, 32'h80000000);
      chk("idle_alu_b", bus.alu_b, 32'h00000001);
      chk("idle_alu_op", 32'(bus.alu_op), 32'd6);
      chk("idle_hs", 32'({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid}), 32'd0);
    end
    @(posedge clk); #1;

    // Backpressure: resp0 held off, req1 waits; stray resp1_ready must be ignored.
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b1;
    drive(vecs[8]);
    @(negedge clk);
    chk("bp_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drive(vecs[3]);
    @(negedge clk);
    chk("bp_exec_ready1", 32'(bus.req1_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rvalid0", 32'(bus.resp0_valid), 32'd1);
      chk("bp_rvalid1", 32'(bus.resp1_valid), 32'd0);
      chk("bp_result", bus.resp_result, 32'hFFFFFFFE);
      chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_take_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    chk("bp_idle_ready1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_sb_empty("bp_drain");

    // Reset during EXEC after a req0 grant: nothing comes back, next tie goes to 0.
    drive(vecs[2]);
    @(negedge clk);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_resp", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
    end
    @(posedge clk); #1;
    drive(vecs[6]);
    drive(vecs[7]);
    @(negedge clk);
    chk("rst_tie_ready0", 32'(bus.req0_ready), 32'd1);
    chk("rst_tie_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_sb_empty("rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
